// File: rtl/spi_burst_fifo_pkg.sv
// Shared definitions for spi_burst_fifo: register offsets, CTRL/STATUS bit
// positions, FSM state encoding and the auto-fill byte value.
package spi_burst_fifo_pkg;

  localparam logic [31:0] OFS_CTRL   = 32'h0;
  localparam logic [31:0] OFS_DATA   = 32'h4;
  localparam logic [31:0] OFS_STATUS = 32'h8;
  localparam logic [31:0] OFS_FILL   = 32'hC;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_RX_DISCARD  = 1;
  localparam int CTRL_TX_FLUSH    = 2;
  localparam int CTRL_RX_FLUSH    = 3;
  localparam int CTRL_IRQ_DONE_EN = 4;
  localparam int CTRL_IRQ_RX_EN   = 5;
  localparam int CTRL_THRESH_LSB  = 8;

  localparam int STAT_RX_CNT_LSB = 16;
  localparam int STAT_BUSY       = 25;
  localparam int STAT_TX_OVF     = 26;
  localparam int STAT_RX_UDF     = 27;

  localparam logic [7:0] FILL_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/spi_burst_fifo_sync_fifo.sv
// sync_fifo: single-clock byte FIFO with first-word fall-through head,
// synchronous flush, and an occupancy count one bit wider than the pointers.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [WIDTH-1:0]      head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int CNT_W = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // A push into a full FIFO is still accepted when a pop frees the head slot
  // in the same cycle; a pop from an empty FIFO is ignored.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign empty   = (count == '0);
  assign full    = count[DEPTH_LOG2];
  assign head    = mem[rd_ptr];

  // Storage array; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; flush has priority over push/pop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/spi_burst_fifo.sv
// spi_burst_fifo: MMIO-fed TX/RX byte FIFOs in front of the SPI byte engine.
// The CPU queues bytes into TX; an issue FSM hands them one at a time to the
// engine and stores each received byte in RX.
// Optional feature: define SPI_BURST_FILL_EN to enable the FILL register
// (auto-generated 0xFF bytes, e.g. for SD-card sector reads).
module spi_burst_fifo
  import spi_burst_fifo_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h80000060,
  parameter int          DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mmio_valid,
  input  logic        mmio_write,
  input  logic [31:0] mmio_addr,
  input  logic [31:0] mmio_wdata,
  input  logic [3:0]  mmio_wstrb,
  output logic [31:0] mmio_rdata,
  output logic        mmio_ready,
  output logic        xfer_start,
  output logic [7:0]  xfer_tx_data,
  input  logic        xfer_done,
  input  logic [7:0]  xfer_rx_data,
  output logic        fifo_irq
);

  state_t state;
  logic en, rx_discard, irq_done_en, irq_rx_en;
  logic [4:0] rx_thresh;
  logic tx_ovf, rx_udf;

  logic acc, wr, rd;
  logic sel_ctrl, sel_data, sel_status, sel_fill;
  logic ctrl_wr, status_wr;
  logic tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic rx_push, rx_pop, rx_flush, rx_full, rx_empty;
  logic [7:0] tx_head, rx_head;
  logic [DEPTH_LOG2:0] tx_count, rx_count;
  logic [8:0] tx_count9, rx_count9;
  logic busy, issue, fill_nz, work_left;
  logic [31:0] fill_rd, rd_val;
  logic unused_bits;

  assign acc        = mmio_valid && !mmio_ready;
  assign wr         = acc && mmio_write;
  assign rd         = acc && !mmio_write;
  assign sel_ctrl   = (mmio_addr == BASE_ADDR + OFS_CTRL);
  assign sel_data   = (mmio_addr == BASE_ADDR + OFS_DATA);
  assign sel_status = (mmio_addr == BASE_ADDR + OFS_STATUS);
  assign sel_fill   = (mmio_addr == BASE_ADDR + OFS_FILL);
  assign ctrl_wr    = wr && sel_ctrl;
  assign status_wr  = wr && sel_status;

  assign tx_push  = wr && sel_data && mmio_wstrb[0];
  assign rx_pop   = rd && sel_data;
  assign tx_flush = ctrl_wr && mmio_wstrb[0] && mmio_wdata[CTRL_TX_FLUSH];
  assign rx_flush = ctrl_wr && mmio_wstrb[0] && mmio_wdata[CTRL_RX_FLUSH];

  assign busy      = (state != ST_IDLE);
  assign work_left = !tx_empty || fill_nz;
  // Issue is only allowed from IDLE, so no byte is ever in flight when RX
  // room is judged; a full RX FIFO therefore blocks the next issue.
  assign issue     = (state == ST_IDLE) && en && work_left && !tx_flush &&
                     (rx_discard || !rx_full);
  assign tx_pop    = issue && !fill_nz;
  assign rx_push   = (state == ST_WAIT) && xfer_done && !rx_discard;

  assign tx_count9 = 9'(tx_count);
  assign rx_count9 = 9'(rx_count);

  assign unused_bits = ^{mmio_wdata[31:13], mmio_wstrb[3:2]};

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk(clk), .resetn(resetn), .push(tx_push), .push_data(mmio_wdata[7:0]),
    .pop(tx_pop), .flush(tx_flush), .head(tx_head), .full(tx_full),
    .empty(tx_empty), .count(tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk(clk), .resetn(resetn), .push(rx_push), .push_data(xfer_rx_data),
    .pop(rx_pop), .flush(rx_flush), .head(rx_head), .full(rx_full),
    .empty(rx_empty), .count(rx_count)
  );

`ifdef SPI_BURST_FILL_EN
  logic [15:0] fill_count;

  // Auto-fill byte counter: loaded only when idle, decremented per issued fill byte.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fill_count <= '0;
    end else if (tx_flush) begin
      fill_count <= '0;
    end else if (wr && sel_fill && mmio_wstrb[0] && !fill_nz) begin
      fill_count <= mmio_wdata[15:0];
    end else if (issue && fill_nz) begin
      fill_count <= fill_count - 16'd1;
    end
  end

  assign fill_nz = (fill_count != 16'd0);
  assign fill_rd = {16'h0, fill_count};
`else
  assign fill_nz = 1'b0;
  assign fill_rd = 32'h0;
`endif

  // CTRL register fields; flush bits are pulses and are not stored.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      en          <= 1'b0;
      rx_discard  <= 1'b0;
      irq_done_en <= 1'b0;
      irq_rx_en   <= 1'b0;
      rx_thresh   <= '0;
    end else if (ctrl_wr) begin
      if (mmio_wstrb[0]) begin
        en          <= mmio_wdata[CTRL_EN];
        rx_discard  <= mmio_wdata[CTRL_RX_DISCARD];
        irq_done_en <= mmio_wdata[CTRL_IRQ_DONE_EN];
        irq_rx_en   <= mmio_wdata[CTRL_IRQ_RX_EN];
      end
      if (mmio_wstrb[1]) rx_thresh <= mmio_wdata[CTRL_THRESH_LSB +: 5];
    end
  end

  // Sticky error flags; any STATUS write clears both.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_ovf <= 1'b0;
      rx_udf <= 1'b0;
    end else if (status_wr) begin
      tx_ovf <= 1'b0;
      rx_udf <= 1'b0;
    end else begin
      if (tx_push && tx_full && !tx_pop) tx_ovf <= 1'b1;
      if (rx_pop && rx_empty)            rx_udf <= 1'b1;
    end
  end

  // Read-data mux for the four mapped registers; anything else reads 0.
  always_comb begin
    rd_val = '0;
    if (sel_ctrl) begin
      rd_val[CTRL_EN]                = en;
      rd_val[CTRL_RX_DISCARD]        = rx_discard;
      rd_val[CTRL_IRQ_DONE_EN]       = irq_done_en;
      rd_val[CTRL_IRQ_RX_EN]         = irq_rx_en;
      rd_val[CTRL_THRESH_LSB +: 5]   = rx_thresh;
    end else if (sel_data) begin
      rd_val[7:0] = rx_empty ? 8'h00 : rx_head;
    end else if (sel_status) begin
      rd_val[8:0]                    = tx_count9;
      rd_val[STAT_RX_CNT_LSB +: 9]   = rx_count9;
      rd_val[STAT_BUSY]              = busy;
      rd_val[STAT_TX_OVF]            = tx_ovf;
      rd_val[STAT_RX_UDF]            = rx_udf;
    end else if (sel_fill) begin
      rd_val = fill_rd;
    end
  end

  // Bus response: one-cycle registered ack for every request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mmio_ready <= 1'b0;
      mmio_rdata <= '0;
    end else begin
      mmio_ready <= acc;
      mmio_rdata <= rd ? rd_val : 32'h0;
    end
  end

  // Issue FSM: IDLE picks the next byte, START pulses the engine, WAIT holds
  // the byte until the engine reports completion.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      xfer_start   <= 1'b0;
      xfer_tx_data <= '0;
    end else begin
      xfer_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (issue) begin
            state        <= ST_START;
            xfer_start   <= 1'b1;
            xfer_tx_data <= fill_nz ? FILL_BYTE : tx_head;
          end
        end
        ST_START: state <= ST_WAIT;
        ST_WAIT:  if (xfer_done) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Level interrupt, registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) fifo_irq <= 1'b0;
    else         fifo_irq <= (irq_done_en && !work_left && !busy) ||
                             (irq_rx_en && (rx_count9 >= {4'h0, rx_thresh}));
  end

endmodule
